// File: rtl/axi_wr_chan_scheduler_pkg.sv
// Shared types and helpers for the AXI write-channel scheduler: AW FSM state
// encoding and a constant-evaluable clog2 used for port and counter widths.
package axi_wr_chan_scheduler_pkg;

  typedef enum logic {
    AW_IDLE = 1'b0,
    AW_HOLD = 1'b1
  } aw_state_e;

  // Smallest width able to index 'value' distinct items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_wr_order_fifo.sv
// Register FIFO holding one-hot AW grants in issue order; the head selects the
// master whose W burst is currently allowed through the W mux.
module axi_wr_order_fifo
  import axi_wr_chan_scheduler_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // NOTE: the storage array has no reset; an empty FIFO masks the head to 0,
  // so stale contents are never visible and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign head  = (count_q != '0) ? mem[rd_ptr] : '0;
  assign count = count_q;

endmodule

// File: rtl/axi_wr_chan_scheduler.sv
// Write-path sequencer for an N:1 AXI crossbar slave port: round-robin AW grant,
// issue-ordered W mux select, and an outstanding-write limiter with B monitoring.
module axi_wr_chan_scheduler
  import axi_wr_chan_scheduler_pkg::*;
#(
  parameter int AXI_MASTER_PORT = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int WORDER_DEPTH    = 4,
  localparam int OUT_W = clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [AXI_MASTER_PORT-1:0] S_AXI_AWVALID_i,
  input  logic                       M_AXI_AWREADY,
  input  logic [AXI_MASTER_PORT-1:0] S_AXI_WVALID_i,
  input  logic [AXI_MASTER_PORT-1:0] S_AXI_WLAST_i,
  input  logic                       M_AXI_WREADY,
  input  logic                       M_AXI_BVALID,
  input  logic                       M_AXI_BREADY,
  output logic [AXI_MASTER_PORT-1:0] aw_gnt_o,
  output logic [AXI_MASTER_PORT-1:0] w_gnt_o,
  output logic [OUT_W-1:0]           outstanding_o,
  output logic                       protocol_err_o
);

  localparam int N     = AXI_MASTER_PORT;
  localparam int PTR_W = clog2(N);
  localparam int Q_W   = clog2(WORDER_DEPTH + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [Q_W-1:0]   Q_FULL  = Q_W'(WORDER_DEPTH);

  aw_state_e        state_q, state_d;
  logic [N-1:0]     aw_gnt_q, aw_gnt_d;
  logic [PTR_W-1:0] win_idx_q, win_idx_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OUT_W-1:0] outstanding_q;
  logic             protocol_err_q;
  logic [N-1:0]     w_head;
  logic [Q_W-1:0]   queue_count;
  logic [N-1:0]     req_rot;
  logic [PTR_W-1:0] rr_win;
  logic             win_found;
  logic             can_grant, aw_hs, w_pop, b_hs;

  function automatic logic [PTR_W-1:0] wrap_idx(input int idx);
    return PTR_W'((idx >= N) ? idx - N : idx);
  endfunction

  // Requests rotated so the pointer position sits at bit 0; first set bit wins.
  always_comb begin
    req_rot   = N'({S_AXI_AWVALID_i, S_AXI_AWVALID_i} >> rr_ptr_q);
    win_found = 1'b0;
    rr_win    = rr_ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        rr_win    = wrap_idx(int'(rr_ptr_q) + i);
      end
    end
  end

  assign can_grant = (|S_AXI_AWVALID_i) && (queue_count < Q_FULL) && (outstanding_q < OUT_MAX);
  assign aw_hs     = (state_q == AW_HOLD) && (|(aw_gnt_q & S_AXI_AWVALID_i)) && M_AXI_AWREADY;
  assign w_pop     = (|(w_head & S_AXI_WVALID_i & S_AXI_WLAST_i)) && M_AXI_WREADY;
  assign b_hs      = M_AXI_BVALID && M_AXI_BREADY;

  // NOTE: every variable gets its hold value first, so no branch can leave one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    aw_gnt_d  = aw_gnt_q;
    win_idx_d = win_idx_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      AW_IDLE: begin
        if (can_grant) begin
          aw_gnt_d  = N'(1) << rr_win;
          win_idx_d = rr_win;
          state_d   = AW_HOLD;
        end
      end
      AW_HOLD: begin
        if (aw_hs) begin
          aw_gnt_d = '0;
          rr_ptr_d = wrap_idx(int'(win_idx_q) + 1);
          state_d  = AW_IDLE;
        end
      end
      default: state_d = AW_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= AW_IDLE;
      aw_gnt_q  <= '0;
      win_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      aw_gnt_q  <= aw_gnt_d;
      win_idx_q <= win_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // The cap is enforced at grant, so a completing AW_HOLD can never overflow.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      outstanding_q  <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      if (aw_hs && !b_hs) outstanding_q <= outstanding_q + 1'b1;
      else if (b_hs && !aw_hs && outstanding_q != '0) outstanding_q <= outstanding_q - 1'b1;
      if (b_hs && outstanding_q == '0) protocol_err_q <= 1'b1;
    end
  end

  axi_wr_order_fifo #(
    .WIDTH (N),
    .DEPTH (WORDER_DEPTH)
  ) u_order_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (aw_hs),
    .push_data (aw_gnt_q),
    .pop       (w_pop),
    .head      (w_head),
    .count     (queue_count)
  );

  assign aw_gnt_o       = aw_gnt_q;
  assign w_gnt_o        = w_head;
  assign outstanding_o  = outstanding_q;
  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_axi_wr_chan_scheduler.sv
// Bench for axi_wr_chan_scheduler: directed scenarios with fixed expectations
// plus a randomized run against a queue-based transaction model.
module tb_axi_wr_chan_scheduler;

  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int MAX   = 8;
  localparam int OUT_W = 4;

  logic             ACLK = 1'b0;
  logic             ARESETN;
  logic [N-1:0]     S_AXI_AWVALID_i;
  logic             M_AXI_AWREADY;
  logic [N-1:0]     S_AXI_WVALID_i;
  logic [N-1:0]     S_AXI_WLAST_i;
  logic             M_AXI_WREADY;
  logic             M_AXI_BVALID;
  logic             M_AXI_BREADY;
  logic [N-1:0]     aw_gnt_o;
  logic [N-1:0]     w_gnt_o;
  logic [OUT_W-1:0] outstanding_o;
  logic             protocol_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state.
  bit m_busy;
  int m_port;
  int m_ptr;
  int m_q[$];
  int m_out;
  bit m_err;

  axi_wr_chan_scheduler #(
    .AXI_MASTER_PORT (N),
    .MAX_OUTSTANDING (MAX),
    .WORDER_DEPTH    (DEPTH)
  ) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .S_AXI_AWVALID_i (S_AXI_AWVALID_i),
    .M_AXI_AWREADY   (M_AXI_AWREADY),
    .S_AXI_WVALID_i  (S_AXI_WVALID_i),
    .S_AXI_WLAST_i   (S_AXI_WLAST_i),
    .M_AXI_WREADY    (M_AXI_WREADY),
    .M_AXI_BVALID    (M_AXI_BVALID),
    .M_AXI_BREADY    (M_AXI_BREADY),
    .aw_gnt_o        (aw_gnt_o),
    .w_gnt_o         (w_gnt_o),
    .outstanding_o   (outstanding_o),
    .protocol_err_o  (protocol_err_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic model_reset();
    m_busy = 1'b0;
    m_port = 0;
    m_ptr  = 0;
    m_q.delete();
    m_out  = 0;
    m_err  = 1'b0;
  endtask

  // One clock of the specification's rules, evaluated on pre-edge inputs.
  task automatic model_step();
    bit aw_hs, w_pop, b_hs;
    int win;
    aw_hs = m_busy && S_AXI_AWVALID_i[m_port] && M_AXI_AWREADY;
    w_pop = (m_q.size() > 0) && S_AXI_WVALID_i[m_q[0]] && S_AXI_WLAST_i[m_q[0]] && M_AXI_WREADY;
    b_hs  = M_AXI_BVALID && M_AXI_BREADY;
    win = -1;
    if (!m_busy && m_q.size() < DEPTH && m_out < MAX)
      for (int k = 0; k < N; k++)
        if (win < 0 && S_AXI_AWVALID_i[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    if (b_hs && m_out == 0) m_err = 1'b1;
    if (aw_hs && !b_hs) m_out++;
    else if (b_hs && !aw_hs && m_out > 0) m_out--;
    if (w_pop) void'(m_q.pop_front());
    if (aw_hs) begin
      m_q.push_back(m_port);
      m_ptr  = (m_port + 1) % N;
      m_busy = 1'b0;
    end
    if (win >= 0) begin
      m_busy = 1'b1;
      m_port = win;
    end
  endtask

  function automatic logic [N-1:0] exp_aw();
    logic [N-1:0] r;
    r = '0;
    if (m_busy) r[m_port] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_w();
    logic [N-1:0] r;
    r = '0;
    if (m_q.size() > 0) r[m_q[0]] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    model_step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic clear_inputs();
    S_AXI_AWVALID_i = '0;
    M_AXI_AWREADY   = 1'b0;
    S_AXI_WVALID_i  = '0;
    S_AXI_WLAST_i   = '0;
    M_AXI_WREADY    = 1'b0;
    M_AXI_BVALID    = 1'b0;
    M_AXI_BREADY    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESETN = 1'b0;
    model_reset();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    S_AXI_AWVALID_i = '1;
    S_AXI_WVALID_i  = '1;
    S_AXI_WLAST_i   = '1;
    M_AXI_AWREADY   = 1'b1;
    M_AXI_WREADY    = 1'b1;
    ARESETN = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    n_tests++;
    if (aw_gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_aw_gnt: got %b expected 00", aw_gnt_o); end
    n_tests++;
    if (w_gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_w_gnt: got %b expected 00", w_gnt_o); end
    n_tests++;
    if (outstanding_o !== 4'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding_o); end
    n_tests++;
    if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", protocol_err_o); end
  endtask

  task automatic test_rr_alternate();
    logic [N-1:0] exp_seq [8];
    exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    do_reset();
    S_AXI_AWVALID_i = 2'b11;
    M_AXI_AWREADY   = 1'b1;
    S_AXI_WVALID_i  = 2'b11;
    S_AXI_WLAST_i   = 2'b11;
    M_AXI_WREADY    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (aw_gnt_o !== exp_seq[i]) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, aw_gnt_o, exp_seq[i]);
      end
    end
    n_tests++;
    if (outstanding_o !== 4'd4) begin n_fail++; $display("FAIL rr_outstanding: got %0d expected 4", outstanding_o); end
    S_AXI_AWVALID_i = 2'b00;
    M_AXI_BVALID    = 1'b1;
    M_AXI_BREADY    = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (outstanding_o !== 4'd0) begin n_fail++; $display("FAIL rr_drain_count: got %0d expected 0", outstanding_o); end
    n_tests++;
    if (w_gnt_o !== 2'b00 || protocol_err_o !== 1'b0) begin
      n_fail++; $display("FAIL rr_drain_state: got w_gnt %b err %b expected 00 0", w_gnt_o, protocol_err_o);
    end
  endtask

  task automatic test_w_order();
    logic [N-1:0] exp_aw_t [10];
    logic [N-1:0] exp_w_t  [10];
    exp_aw_t = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_w_t  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    do_reset();
    M_AXI_AWREADY  = 1'b1;
    M_AXI_WREADY   = 1'b1;
    S_AXI_WVALID_i = 2'b11;
    for (int i = 0; i < 10; i++) begin
      S_AXI_AWVALID_i = (i < 2) ? 2'b10 : (i < 4) ? 2'b01 : 2'b00;
      S_AXI_WLAST_i   = (i == 5) ? 2'b10 : (i == 9) ? 2'b01 : 2'b00;
      tick();
      n_tests++;
      if (aw_gnt_o !== exp_aw_t[i]) begin
        n_fail++; $display("FAIL worder_aw[%0d]: got %b expected %b", i, aw_gnt_o, exp_aw_t[i]);
      end
      n_tests++;
      if (w_gnt_o !== exp_w_t[i]) begin
        n_fail++; $display("FAIL worder_w[%0d]: got %b expected %b", i, w_gnt_o, exp_w_t[i]);
      end
    end
  endtask

  task automatic test_outstanding_cap();
    do_reset();
    S_AXI_AWVALID_i = 2'b01;
    M_AXI_AWREADY   = 1'b1;
    S_AXI_WVALID_i  = 2'b01;
    S_AXI_WLAST_i   = 2'b01;
    M_AXI_WREADY    = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    n_tests++;
    if (outstanding_o !== 4'd8) begin n_fail++; $display("FAIL cap_count_full: got %0d expected 8", outstanding_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (aw_gnt_o !== 2'b00) begin n_fail++; $display("FAIL cap_hold_off[%0d]: got %b expected 00", i, aw_gnt_o); end
    end
    M_AXI_BVALID = 1'b1;
    M_AXI_BREADY = 1'b1;
    tick();
    M_AXI_BVALID = 1'b0;
    n_tests++;
    if (outstanding_o !== 4'd7 || aw_gnt_o !== 2'b00) begin
      n_fail++; $display("FAIL cap_after_b: got count %0d gnt %b expected 7 00", outstanding_o, aw_gnt_o);
    end
    tick();
    n_tests++;
    if (aw_gnt_o !== 2'b01) begin n_fail++; $display("FAIL cap_regrant: got %b expected 01", aw_gnt_o); end
    tick();
    n_tests++;
    if (outstanding_o !== 4'd8) begin n_fail++; $display("FAIL cap_count_back: got %0d expected 8", outstanding_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    S_AXI_AWVALID_i = 2'b01;
    M_AXI_AWREADY   = 1'b1;
    S_AXI_WVALID_i  = 2'b01;
    S_AXI_WLAST_i   = 2'b01;
    M_AXI_WREADY    = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_tests++;
    if (outstanding_o !== 4'd3 || aw_gnt_o !== 2'b01) begin
      n_fail++; $display("FAIL simul_setup: got count %0d gnt %b expected 3 01", outstanding_o, aw_gnt_o);
    end
    M_AXI_BVALID = 1'b1;
    M_AXI_BREADY = 1'b1;
    tick();
    n_tests++;
    if (outstanding_o !== 4'd3 || aw_gnt_o !== 2'b00) begin
      n_fail++; $display("FAIL simul_aw_and_b: got count %0d gnt %b expected 3 00", outstanding_o, aw_gnt_o);
    end
    S_AXI_AWVALID_i = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (outstanding_o !== 4'd0 || protocol_err_o !== 1'b0) begin
      n_fail++; $display("FAIL simul_drain: got count %0d err %b expected 0 0", outstanding_o, protocol_err_o);
    end
    tick();
    M_AXI_BVALID = 1'b0;
    n_tests++;
    if (outstanding_o !== 4'd0 || protocol_err_o !== 1'b1) begin
      n_fail++; $display("FAIL simul_b_at_zero: got count %0d err %b expected 0 1", outstanding_o, protocol_err_o);
    end
    S_AXI_AWVALID_i = 2'b01;
    tick();
    tick();
    S_AXI_AWVALID_i = 2'b00;
    n_tests++;
    if (outstanding_o !== 4'd1 || protocol_err_o !== 1'b1) begin
      n_fail++; $display("FAIL simul_err_sticky: got count %0d err %b expected 1 1", outstanding_o, protocol_err_o);
    end
  endtask

  task automatic test_queue_full();
    do_reset();
    S_AXI_AWVALID_i = 2'b11;
    M_AXI_AWREADY   = 1'b1;
    S_AXI_WVALID_i  = 2'b11;
    S_AXI_WLAST_i   = 2'b11;
    M_AXI_WREADY    = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (aw_gnt_o !== 2'b00) begin n_fail++; $display("FAIL qfull_no_grant[%0d]: got %b expected 00", i, aw_gnt_o); end
    end
    n_tests++;
    if (outstanding_o !== 4'd4 || w_gnt_o !== 2'b01) begin
      n_fail++; $display("FAIL qfull_state: got count %0d w_gnt %b expected 4 01", outstanding_o, w_gnt_o);
    end
    M_AXI_WREADY = 1'b1;
    tick();
    M_AXI_WREADY = 1'b0;
    n_tests++;
    if (aw_gnt_o !== 2'b00 || w_gnt_o !== 2'b10) begin
      n_fail++; $display("FAIL qfull_pop: got aw %b w %b expected 00 10", aw_gnt_o, w_gnt_o);
    end
    tick();
    n_tests++;
    if (aw_gnt_o !== 2'b01) begin n_fail++; $display("FAIL qfull_regrant: got %b expected 01", aw_gnt_o); end
    // A non-last beat is in flight when reset hits.
    S_AXI_WLAST_i = 2'b00;
    M_AXI_WREADY  = 1'b1;
    tick();
    #2;
    ARESETN = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (aw_gnt_o !== 2'b00 || w_gnt_o !== 2'b00 || outstanding_o !== 4'd0) begin
      n_fail++; $display("FAIL async_reset: got aw %b w %b count %0d expected 00 00 0", aw_gnt_o, w_gnt_o, outstanding_o);
    end
    clear_inputs();
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    tick();
    n_tests++;
    if (aw_gnt_o !== 2'b00 || w_gnt_o !== 2'b00 || outstanding_o !== 4'd0 || protocol_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_resume: got aw %b w %b count %0d err %b expected all 0",
                         aw_gnt_o, w_gnt_o, outstanding_o, protocol_err_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      S_AXI_AWVALID_i = N'($urandom_range(0, 3));
      M_AXI_AWREADY   = ($urandom_range(0, 1) == 1);
      S_AXI_WVALID_i  = N'($urandom_range(0, 3));
      S_AXI_WLAST_i   = N'($urandom_range(0, 3)) & N'($urandom_range(0, 3));
      M_AXI_WREADY    = ($urandom_range(0, 1) == 1);
      M_AXI_BVALID    = (m_out > 0) && ($urandom_range(0, 3) == 0);
      M_AXI_BREADY    = ($urandom_range(0, 3) != 0);
      tick();
      n_tests++;
      if (aw_gnt_o !== exp_aw()) begin
        n_fail++; $display("FAIL rand_aw_gnt[%0d]: got %b expected %b", i, aw_gnt_o, exp_aw());
      end
      n_tests++;
      if (w_gnt_o !== exp_w()) begin
        n_fail++; $display("FAIL rand_w_gnt[%0d]: got %b expected %b", i, w_gnt_o, exp_w());
      end
      n_tests++;
      if (outstanding_o !== OUT_W'(m_out)) begin
        n_fail++; $display("FAIL rand_outstanding[%0d]: got %0d expected %0d", i, outstanding_o, m_out);
      end
      n_tests++;
      if (protocol_err_o !== m_err) begin
        n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", i, protocol_err_o, m_err);
      end
    end
  endtask

  initial begin
    clear_inputs();
    ARESETN = 1'b0;
    model_reset();
    test_reset();
    test_rr_alternate();
    test_w_order();
    test_outstanding_cap();
    test_simultaneous();
    test_queue_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
